// File: rtl/dut_cfg_scan_emulator_pkg.sv
// ---------------------------------------------------------------------------
// cms_pix28_package
// Shared constants and types for the pix28 DUT configuration/scan emulator.
//   DUT_EMU_CFG_LEN_DEF   default configuration shift-register length
//   DUT_EMU_SCAN_LEN_DEF  default scan-chain length
//   dut_emu_edge_cnt_t    16-bit config_clk edge counter type
//   edge_cnt_inc()        saturating increment for the edge counter
// ---------------------------------------------------------------------------
package cms_pix28_package;

    localparam int DUT_EMU_CFG_LEN_DEF  = 32;
    localparam int DUT_EMU_SCAN_LEN_DEF = 48;

    typedef logic [15:0] dut_emu_edge_cnt_t;

    // Holds at 0xFFFF so an over-long shift can never wrap back to CFG_LEN
    // and hide a length error.
    function automatic dut_emu_edge_cnt_t edge_cnt_inc(input dut_emu_edge_cnt_t cnt);
        if (cnt == 16'hFFFF) begin
            return cnt;
        end
        return cnt + 16'd1;
    endfunction

endpackage

// File: rtl/dut_cfg_scan_emulator_if.sv
// ---------------------------------------------------------------------------
// dut_cfg_scan_emulator_if
// Pin-level bundle between the FPGA firmware (master) and the emulated pix28
// DUT (slave).
//   master: drives strobes, serial data and scan patterns; reads serial outs
//   slave : the emulator; reads strobes/data, drives config_out/scan_out
// Parameter SCAN_LEN sets the width of the scan load patterns.
// ---------------------------------------------------------------------------
interface dut_cfg_scan_emulator_if #(
    parameter int SCAN_LEN = 48
);
    logic                super_pixel_sel;
    logic                config_clk;
    logic                reset_not;
    logic                config_in;
    logic                config_load;
    logic                bxclk;
    logic                scan_in;
    logic                scan_load;
    logic [SCAN_LEN-1:0] scan_pattern_0;
    logic [SCAN_LEN-1:0] scan_pattern_1;
    logic                config_out;
    logic                scan_out;

    modport master (
        output super_pixel_sel, config_clk, reset_not, config_in, config_load,
               bxclk, scan_in, scan_load, scan_pattern_0, scan_pattern_1,
        input  config_out, scan_out
    );

    modport slave (
        input  super_pixel_sel, config_clk, reset_not, config_in, config_load,
               bxclk, scan_in, scan_load, scan_pattern_0, scan_pattern_1,
        output config_out, scan_out
    );
endinterface

// File: rtl/dut_cfg_scan_emulator_edge_det.sv
// ---------------------------------------------------------------------------
// dut_emu_edge_det
// One-bit registered edge detector for an oversampled pin strobe.
//   clk, rst_n : oversampling clock, async active-low reset (d_q resets to 0)
//   d          : pin level
//   rise       : d high now, low at previous sample
//   fall       : d low now, high at previous sample
// Because d_q resets to 0, a strobe that is already high when reset releases
// reports one rise on the first sample.
// ---------------------------------------------------------------------------
module dut_emu_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic d_q;
    logic d_d;

    assign d_d = d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_d;
        end
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;
endmodule

// File: rtl/dut_cfg_scan_emulator.sv
// ---------------------------------------------------------------------------
// dut_cfg_scan_emulator
// Fabric model of the pix28 configuration and scan chains, oversampled on
// iob_clk, used as a closed-loop target for the firmware.
//   iob_clk      : oversampling clock (rising edge)
//   reset_n      : async active-low reset, clears every register
//   pins         : pin bundle (slave side), strobes in, config_out/scan_out
//   cfg_shadow   : last committed configuration word
//   cfg_load_cnt : number of commits, wraps at 255
//   cfg_len_err  : sticky, a commit saw an edge count other than CFG_LEN
// Build option: DUT_EMU_SCAN_EN compiles in the scan chain; without it
// scan_out is tied low and the scan inputs are ignored.
// ---------------------------------------------------------------------------
module dut_cfg_scan_emulator
    import cms_pix28_package::*;
#(
    parameter int CFG_LEN  = DUT_EMU_CFG_LEN_DEF,
    parameter int SCAN_LEN = DUT_EMU_SCAN_LEN_DEF
) (
    input  logic                   iob_clk,
    input  logic                   reset_n,
    dut_cfg_scan_emulator_if.slave pins,
    output logic [CFG_LEN-1:0]     cfg_shadow,
    output logic [7:0]             cfg_load_cnt,
    output logic                   cfg_len_err
);
    logic cfg_clk_rise;
    logic unused_cfg_clk_fall;
    logic unused_cfg_load_rise;
    logic cfg_load_fall;

    dut_emu_edge_det u_edge_config_clk (
        .clk   (iob_clk),
        .rst_n (reset_n),
        .d     (pins.config_clk),
        .rise  (cfg_clk_rise),
        .fall  (unused_cfg_clk_fall)
    );

    dut_emu_edge_det u_edge_config_load (
        .clk   (iob_clk),
        .rst_n (reset_n),
        .d     (pins.config_load),
        .rise  (unused_cfg_load_rise),
        .fall  (cfg_load_fall)
    );

    logic [CFG_LEN-1:0] cfg_sr_q,      cfg_sr_d;
    logic [CFG_LEN-1:0] cfg_shadow_q,  cfg_shadow_d;
    logic [7:0]         cfg_load_cnt_q, cfg_load_cnt_d;
    logic               cfg_len_err_q, cfg_len_err_d;
    dut_emu_edge_cnt_t  edge_cnt_q,    edge_cnt_d;

    always_comb begin
        cfg_sr_d       = cfg_sr_q;
        cfg_shadow_d   = cfg_shadow_q;
        cfg_load_cnt_d = cfg_load_cnt_q;
        cfg_len_err_d  = cfg_len_err_q;
        edge_cnt_d     = edge_cnt_q;

        if (!pins.reset_not) begin
            // Functional reset keeps the commit counter so firmware can still
            // see how many loads happened across DUT resets.
            cfg_sr_d      = '0;
            cfg_shadow_d  = '0;
            cfg_len_err_d = 1'b0;
            edge_cnt_d    = '0;
        end else begin
            // Gating on the live config_load level means a rise coinciding
            // with the load fall is dropped and the commit sees pre-shift data.
            if (cfg_clk_rise && pins.config_load) begin
                cfg_sr_d   = {cfg_sr_q[CFG_LEN-2:0], pins.config_in};
                edge_cnt_d = edge_cnt_inc(edge_cnt_q);
            end
            if (cfg_load_fall) begin
                cfg_shadow_d   = cfg_sr_q;
                cfg_load_cnt_d = cfg_load_cnt_q + 8'd1;
                if (edge_cnt_q != dut_emu_edge_cnt_t'(CFG_LEN)) begin
                    cfg_len_err_d = 1'b1;
                end
                edge_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge iob_clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_sr_q       <= '0;
            cfg_shadow_q   <= '0;
            cfg_load_cnt_q <= '0;
            cfg_len_err_q  <= 1'b0;
            edge_cnt_q     <= '0;
        end else begin
            cfg_sr_q       <= cfg_sr_d;
            cfg_shadow_q   <= cfg_shadow_d;
            cfg_load_cnt_q <= cfg_load_cnt_d;
            cfg_len_err_q  <= cfg_len_err_d;
            edge_cnt_q     <= edge_cnt_d;
        end
    end

    assign pins.config_out = cfg_sr_q[CFG_LEN-1];
    assign cfg_shadow      = cfg_shadow_q;
    assign cfg_load_cnt    = cfg_load_cnt_q;
    assign cfg_len_err     = cfg_len_err_q;

`ifdef DUT_EMU_SCAN_EN
    logic bxclk_rise;
    logic unused_bxclk_fall;

    dut_emu_edge_det u_edge_bxclk (
        .clk   (iob_clk),
        .rst_n (reset_n),
        .d     (pins.bxclk),
        .rise  (bxclk_rise),
        .fall  (unused_bxclk_fall)
    );

    logic [SCAN_LEN-1:0] scan_sr_q, scan_sr_d;

    always_comb begin
        scan_sr_d = scan_sr_q;
        if (!pins.reset_not) begin
            scan_sr_d = '0;
        end else if (bxclk_rise) begin
            if (pins.scan_load) begin
                scan_sr_d = pins.super_pixel_sel ? pins.scan_pattern_1 : pins.scan_pattern_0;
            end else begin
                scan_sr_d = {scan_sr_q[SCAN_LEN-2:0], pins.scan_in};
            end
        end
    end

    always_ff @(posedge iob_clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_sr_q <= '0;
        end else begin
            scan_sr_q <= scan_sr_d;
        end
    end

    assign pins.scan_out = scan_sr_q[SCAN_LEN-1];
`else
    logic                unused_scan_ctl;
    logic [SCAN_LEN-1:0] unused_scan_pat;

    assign unused_scan_ctl = pins.bxclk ^ pins.scan_in ^ pins.scan_load ^ pins.super_pixel_sel;
    assign unused_scan_pat = pins.scan_pattern_0 ^ pins.scan_pattern_1;
    assign pins.scan_out   = 1'b0;
`endif
endmodule

// File: tb/tb_dut_cfg_scan_emulator.sv
module tb_dut_cfg_scan_emulator;
    logic        iob_clk = 1'b0;
    logic        reset_n;
    logic [31:0] cfg_shadow;
    logic [7:0]  cfg_load_cnt;
    logic        cfg_len_err;
    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] seen;

    always #5 iob_clk = ~iob_clk;

    dut_cfg_scan_emulator_if #(.SCAN_LEN(48)) pins ();

    dut_cfg_scan_emulator #(.CFG_LEN(32), .SCAN_LEN(48)) dut (
        .iob_clk      (iob_clk),
        .reset_n      (reset_n),
        .pins         (pins),
        .cfg_shadow   (cfg_shadow),
        .cfg_load_cnt (cfg_load_cnt),
        .cfg_len_err  (cfg_len_err)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge iob_clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Shifts w[n-1]..w[0] at minimum strobe timing; records config_out before each bit.
    task automatic shift_word(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            seen = {seen[62:0], pins.config_out};
            pins.config_in  = w[i];
            pins.config_clk = 1'b1;
            tick(1);
            pins.config_clk = 1'b0;
            tick(1);
        end
    endtask

    task automatic commit();
        pins.config_load = 1'b0;
        tick(1);
        pins.config_load = 1'b1;
        tick(1);
    endtask

    task automatic dut_reset_pulse();
        pins.reset_not = 1'b0;
        tick(1);
        pins.reset_not = 1'b1;
        tick(1);
    endtask

    task automatic bx_pulse();
        pins.bxclk = 1'b1;
        tick(1);
        pins.bxclk = 1'b0;
        tick(1);
    endtask

    initial begin
        reset_n              = 1'b0;
        pins.super_pixel_sel = 1'b0;
        pins.config_clk      = 1'b0;
        pins.reset_not       = 1'b1;
        pins.config_in       = 1'b0;
        pins.config_load     = 1'b1;
        pins.bxclk           = 1'b0;
        pins.scan_in         = 1'b0;
        pins.scan_load       = 1'b0;
        pins.scan_pattern_0  = '0;
        pins.scan_pattern_1  = '0;
        seen                 = '0;
        tick(3);

        check("rst_config_out", 64'(pins.config_out), 64'd0);
        check("rst_scan_out",   64'(pins.scan_out),   64'd0);
        check("rst_shadow",     64'(cfg_shadow),      64'd0);
        check("rst_load_cnt",   64'(cfg_load_cnt),    64'd0);
        check("rst_len_err",    64'(cfg_len_err),     64'd0);
        reset_n = 1'b1;
        tick(2);

        // Nominal load
        shift_word(32'hA5C3_0F96, 32);
        commit();
        check("nom_shadow",   64'(cfg_shadow),   64'hA5C3_0F96);
        check("nom_load_cnt", 64'(cfg_load_cnt), 64'd1);
        check("nom_len_err",  64'(cfg_len_err),  64'd0);

        // Readback of the first word during the second shift
        shift_word(32'h1234_5678, 32);
        check("replay_out", 64'(seen[31:0]), 64'hA5C3_0F96);
        commit();
        check("nom2_shadow",   64'(cfg_shadow),   64'h1234_5678);
        check("nom2_load_cnt", 64'(cfg_load_cnt), 64'd2);

        // Short shift -> sticky length error
        shift_word(32'h7FFF_FFFF, 31);
        commit();
        check("short_shadow",  64'(cfg_shadow),   64'h7FFF_FFFF);
        check("short_len_err", 64'(cfg_len_err),  64'd1);
        check("short_cnt",     64'(cfg_load_cnt), 64'd3);
        shift_word(32'hDEAD_BEEF, 32);
        commit();
        check("sticky_shadow",  64'(cfg_shadow),   64'hDEAD_BEEF);
        check("sticky_len_err", 64'(cfg_len_err),  64'd1);
        check("sticky_cnt",     64'(cfg_load_cnt), 64'd4);

        // Functional reset clears error/shadow/sr, keeps commit count
        dut_reset_pulse();
        check("rnot_len_err",    64'(cfg_len_err),     64'd0);
        check("rnot_shadow",     64'(cfg_shadow),      64'd0);
        check("rnot_config_out", 64'(pins.config_out), 64'd0);
        check("rnot_cnt",        64'(cfg_load_cnt),    64'd4);

        // config_clk rise in the same cycle as config_load fall
        shift_word(32'hCAFE_F00D, 32);
        pins.config_in   = 1'b1;
        pins.config_clk  = 1'b1;
        pins.config_load = 1'b0;
        tick(1);
        pins.config_clk  = 1'b0;
        pins.config_load = 1'b1;
        tick(1);
        check("simul_shadow",  64'(cfg_shadow),   64'hCAFE_F00D);
        check("simul_len_err", 64'(cfg_len_err),  64'd0);
        check("simul_cnt",     64'(cfg_load_cnt), 64'd5);
        commit();
        check("simul_sr_kept", 64'(cfg_shadow),   64'hCAFE_F00D);
        check("zero_len_err",  64'(cfg_len_err),  64'd1);
        check("zero_cnt",      64'(cfg_load_cnt), 64'd6);

        // Async reset mid-shift
        shift_word(32'h0000_03FF, 10);
        check("pre_rst_out", 64'(pins.config_out), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_config_out", 64'(pins.config_out), 64'd0);
        check("arst_shadow",     64'(cfg_shadow),      64'd0);
        check("arst_cnt",        64'(cfg_load_cnt),    64'd0);
        check("arst_len_err",    64'(cfg_len_err),     64'd0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        shift_word(32'h0F1E_2D3C, 32);
        commit();
        check("post_arst_shadow",  64'(cfg_shadow),   64'h0F1E_2D3C);
        check("post_arst_cnt",     64'(cfg_load_cnt), 64'd1);
        check("post_arst_len_err", 64'(cfg_len_err),  64'd0);

        // 64 bits at minimum strobe timing
        shift_word(32'h1357_9BDF, 32);
        shift_word(32'h2468_ACE0, 32);
        commit();
        check("min_shadow",  64'(cfg_shadow),   64'h2468_ACE0);
        check("min_cnt",     64'(cfg_load_cnt), 64'd2);
        check("min_len_err", 64'(cfg_len_err),  64'd1);

`ifdef DUT_EMU_SCAN_EN
        pins.scan_pattern_0  = 48'h0000_0000_0001;
        pins.scan_pattern_1  = 48'h8000_0000_0000;
        pins.super_pixel_sel = 1'b0;
        pins.scan_load       = 1'b1;
        bx_pulse();
        pins.scan_load       = 1'b0;
        pins.scan_in         = 1'b0;
        check("scan_load0_out", 64'(pins.scan_out), 64'd0);
        for (int i = 0; i < 46; i++) bx_pulse();
        check("scan_46_out", 64'(pins.scan_out), 64'd0);
        bx_pulse();
        check("scan_47_out", 64'(pins.scan_out), 64'd1);
        bx_pulse();
        check("scan_48_out", 64'(pins.scan_out), 64'd0);
        pins.super_pixel_sel = 1'b1;
        pins.scan_load       = 1'b1;
        pins.scan_in         = 1'b0;
        bx_pulse();
        pins.scan_load       = 1'b0;
        check("scan_load1_out", 64'(pins.scan_out), 64'd1);
`else
        pins.scan_pattern_0  = '1;
        pins.scan_pattern_1  = '1;
        pins.super_pixel_sel = 1'b1;
        pins.scan_load       = 1'b1;
        bx_pulse();
        pins.scan_load       = 1'b0;
        pins.scan_in         = 1'b1;
        bx_pulse();
        check("scan_off_out", 64'(pins.scan_out), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dut_cfg_scan_emulator.md
# dut_cfg_scan_emulator

Synthesizable fabric model of the CMS pix28 DUT configuration and scan chains, clocked by `iob_clk`. It sits on the DUT side of the FPGA pin interface and serves as a closed-loop test target for the fw_ip firmwares. It oversamples the pin-level strobes (`config_clk`, `config_load`, `bxclk`, `scan_load`, `reset_not`) and shifts serial data through internal registers. It drives `config_out` and `scan_out` back exactly as the chip would, with a shadow register and error flags that the bench and on-board debug can observe.

## Interface
- `CFG_LEN`, default 32: configuration shift-register length in bits, range 2..1024.
- `SCAN_LEN`, default 48: scan-chain length in bits, range 2..1024.
- `iob_clk` in 1: 400 MHz oversampling clock. All logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `super_pixel_sel` in 1: selects the scan parallel-load pattern; 0 selects `scan_pattern_0`, 1 selects `scan_pattern_1`.
- `config_clk` in 1: DUT configuration shift clock, pin level.
- `reset_not` in 1: DUT functional reset, active low, level sensitive.
- `config_in` in 1: configuration serial data in.
- `config_load` in 1: idle high. A falling edge commits the shift register to the shadow register.
- `bxclk` in 1: bunch-crossing clock; scan shift strobe.
- `scan_in` in 1: scan serial data in.
- `scan_load` in 1: scan parallel-load enable, active high.
- `scan_pattern_0` in SCAN_LEN: scan load pattern for super-pixel 0.
- `scan_pattern_1` in SCAN_LEN: scan load pattern for super-pixel 1.
- `config_out` out 1: configuration serial out, equal to `cfg_sr[CFG_LEN-1]`.
- `scan_out` out 1: scan serial out, equal to `scan_sr[SCAN_LEN-1]`.
- `cfg_shadow` out CFG_LEN: last committed configuration word.
- `cfg_load_cnt` out 8: count of shadow commits; wraps 255→0.
- `cfg_len_err` out 1: sticky flag; a commit occurred with an edge count not equal to CFG_LEN.

## Operation
- **Input sampling.** Each strobe input passes through one register stage (`*_q`).
  - Rising edge on a strobe = current pin value AND NOT `*_q`.
  - Falling edge = NOT current AND `*_q`.
  - Data inputs are sampled in the same cycle the edge is detected.
- **Functional reset.** `reset_not`=0 takes priority over everything and acts synchronously. It clears:
  - `cfg_sr`, `scan_sr`, `cfg_shadow`
  - the edge counter, `cfg_len_err`
  - it does NOT clear `cfg_load_cnt`.
- **Config shift.** On a `config_clk` rise while `config_load`=1:
  - `cfg_sr <= {cfg_sr[CFG_LEN-2:0], config_in}`.
  - The 16-bit edge counter increments, saturating at 0xFFFF.
- **Config commit.** On a `config_load` fall:
  - `cfg_shadow <= cfg_sr`; `cfg_load_cnt` increments.
  - `cfg_len_err` is set if the edge counter ≠ CFG_LEN.
  - The edge counter is then cleared.
- `config_clk` rises while `config_load`=0 are ignored and are not counted.
- **Simultaneous config rise and load fall.** The shift is suppressed because the sampled `config_load` is 0. The commit captures the pre-shift value.
- **Scan chain**, on a `bxclk` rise:
  - If `scan_load`=1: `scan_sr <= super_pixel_sel ? scan_pattern_1 : scan_pattern_0`.
  - Otherwise: `scan_sr <= {scan_sr[SCAN_LEN-2:0], scan_in}`.
  - Load has priority over shift.
- `bxclk_ana` and `vin_test_trig_out` are not modelled.

## Timing
- **Reset values** (`reset_n`=0): all registers are 0. Therefore:
  - `config_out`=0, `scan_out`=0
  - `cfg_shadow`=0, `cfg_load_cnt`=0, `cfg_len_err`=0
  - all `*_q` = 0
- **Edge after reset release.** The first sample after `reset_n` deasserts treats a high strobe as a rising edge. Firmware holds `config_clk` and `bxclk` low at that point.
- **Latency.** A pin edge sampled at clock t updates the register at clock t+1, and `config_out`/`scan_out` are valid after t+1.
  - Pin-to-serial-out total: 2 `iob_clk` cycles.
- **Minimum strobe phase.** 1 `iob_clk` cycle high and 1 cycle low. `config_in`/`scan_in` must be stable at the sampling edge.
- **Reset mid-operation.** A `reset_n` assertion aborts any partial shift immediately. A `reset_not` pulse has the same effect on the next cycle.

## Configuration
- **`DUT_EMU_SCAN_EN`**
  - Defined: the scan chain and `scan_pattern_*` handling are compiled in.
  - Undefined: `scan_sr` is absent, `scan_out` is tied to 0, and the scan inputs are unused. The config path is unchanged.

## Structure
- Shared constants go in `cms_pix28_package`: `DUT_EMU_CFG_LEN_DEF`, `DUT_EMU_SCAN_LEN_DEF`, and `typedef logic [15:0] dut_emu_edge_cnt_t`.
- One sub-module, `dut_emu_edge_det`:
  - One-bit registered edge detector with outputs `rise` and `fall`.
  - Instantiated per strobe.

## Test plan
- **Nominal config load.** Reset, then shift 32 bits of 0xA5C3_0F96, MSB first, then pulse `config_load` low.
  - `cfg_shadow`=0xA5C3_0F96, `cfg_load_cnt`=1, `cfg_len_err`=0.
  - During a second 32-bit shift, `config_out` replays the first word MSB-first.
- **Length error.** Shift 31 bits, then commit → `cfg_len_err`=1 and stays set after a correct 32-bit commit. A `reset_not` pulse clears it; `cfg_load_cnt` is retained.
- **Simultaneous events.**
  - `config_clk` rise in the same cycle as a `config_load` fall → `cfg_sr` unchanged, shadow gets the prior value.
  - `scan_load`=1 with a `bxclk` rise and `super_pixel_sel`=1 → `scan_sr`=`scan_pattern_1`.
- **Scan readback.** Load `scan_pattern_0`=48'h0000_0000_0001, then apply 47 `bxclk` rises with `scan_in`=0 → `scan_out`=1 only after the 47th shift.
- **Async reset mid-shift.** Assert `reset_n` after 10 config bits → all outputs 0 immediately. A full 32-bit load after release succeeds.
- **Minimum timing.** Run `config_clk` at 1 cycle high / 1 cycle low for 64 bits → no edges missed; the counter equals 64 at commit, so `cfg_len_err`=1 for CFG_LEN=32.
